// File: rtl/key_enc164_if.sv
// Report handshake between the keypad encoder and its consumer (7-seg driver or control FSM).
// The encoder drives the master side; the consumer drives the acknowledge on the slave side.
interface key_enc164_if;
    logic [3:0] code;
    logic       codeValid;
    logic       codeAck;

    modport master (
        output code,
        output codeValid,
        input  codeAck
    );

    modport slave (
        input  code,
        input  codeValid,
        output codeAck
    );
endinterface

// File: rtl/key_enc164.sv
// Sequential 16:4 priority encoder: synchronizes, debounces and reports one keypad code per press.
// Optional auto-repeat while the key stays held is compiled in with `define KEY_ENC_REPEAT_EN.
module key_enc164 #(
    parameter int DB_CYCLES     = 16,
    parameter int REPEAT_CYCLES = 256
) (
    input  logic          clk,
    input  logic          resetL,
    input  logic [15:0]   keys,
    input  logic          enable,
    output logic          anyKey,
    key_enc164_if.master  rep
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    // Out-of-range parameters would silently break the counter compare.
    generate
        if (DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_badDbCycles
            $error("key_enc164: DB_CYCLES must be in 2..65535");
        end
        if (REPEAT_CYCLES < 2) begin : g_badRepeatCycles
            $error("key_enc164: REPEAT_CYCLES must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        REPORT       = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [15:0]     r_sync1;
    logic [15:0]     r_sync2;
    logic            r_anyKey;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cntNext;
    logic [3:0]      r_cand;
    logic [3:0]      w_candNext;
    logic [3:0]      r_code;
    logic [3:0]      w_codeNext;
    logic            w_sAny;
    logic [3:0]      w_pe;

`ifdef KEY_ENC_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0]   r_rep;
    logic [RW-1:0]   w_repNext;
`endif

    function automatic logic [3:0] prioEnc(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_anyKey <= 1'b0;
        end else begin
            r_sync1  <= keys;
            r_sync2  <= r_sync1;
            r_anyKey <= |r_sync2;
        end
    end

    assign w_sAny = |r_sync2;
    assign w_pe   = prioEnc(r_sync2);
    assign anyKey = r_anyKey;

    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= 4'h0;
            r_code  <= 4'h0;
`ifdef KEY_ENC_REPEAT_EN
            r_rep   <= '0;
`endif
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_cand  <= w_candNext;
            r_code  <= w_codeNext;
`ifdef KEY_ENC_REPEAT_EN
            r_rep   <= w_repNext;
`endif
        end
    end

    // r_cnt is the press debounce count in DEBOUNCE and the release count in WAIT_RELEASE.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_candNext  = r_cand;
        w_codeNext  = r_code;
`ifdef KEY_ENC_REPEAT_EN
        w_repNext   = '0;
`endif
        case (r_state)
            IDLE: begin
                w_cntNext = '0;
                if (enable && w_sAny) begin
                    w_candNext  = w_pe;
                    w_stateNext = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!enable || !w_sAny || (w_pe != r_cand)) begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_codeNext  = r_cand;
                    w_stateNext = REPORT;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            REPORT: begin
                if (rep.codeAck) begin
                    w_stateNext = WAIT_RELEASE;
                    w_cntNext   = '0;
                end
            end
            WAIT_RELEASE: begin
`ifdef KEY_ENC_REPEAT_EN
                if (w_sAny && (w_pe == r_code)) begin
                    if (r_rep == REP_LAST) begin
                        w_repNext   = '0;
                        w_stateNext = REPORT;
                    end else begin
                        w_repNext = r_rep + 1'b1;
                    end
                end
`endif
                if (w_sAny) begin
                    w_cntNext = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_stateNext = IDLE;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    // A report is pending exactly while the FSM sits in REPORT.
    always_comb begin
        rep.codeValid = (r_state == REPORT);
        rep.code      = r_code;
    end

endmodule

// File: tb/tb_key_enc164.sv
// Directed self-checking bench for key_enc164 at default parameters (DB_CYCLES=16).
// Define KEY_ENC_REPEAT_EN for both RTL and bench to exercise the auto-repeat path.
module tb_key_enc164;

    logic        clk;
    logic        resetL;
    logic [15:0] keys;
    logic        enable;
    logic        anyKey;
    int          checks;
    int          errors;
    int          n;
    bit          sawValid;
    bit          sawAny;
    bit          sawValid2;
    bit          sawAny2;

    key_enc164_if rep ();

    key_enc164 dut (
        .clk    (clk),
        .resetL (resetL),
        .keys   (keys),
        .enable (enable),
        .anyKey (anyKey),
        .rep    (rep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Counts edges until codeValid rises; returns maxC when it never does.
    task automatic waitValid(input int maxC, output int edges);
        edges = 0;
        while (edges < maxC) begin
            tick();
            edges++;
            if (rep.codeValid) break;
        end
    endtask

    task automatic watchQuiet(input int cyc, output bit v, output bit a);
        v = 1'b0;
        a = 1'b0;
        repeat (cyc) begin
            tick();
            v = v | rep.codeValid;
            a = a | anyKey;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] k, output int edges);
        keys = k;
        waitValid(60, edges);
    endtask

    task automatic ackOnce();
        rep.codeAck = 1'b1;
        tick();
        rep.codeAck = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        keys        = 16'h0000;
        enable      = 1'b1;
        rep.codeAck = 1'b0;
        resetL      = 1'b0;
        repeat (3) tick();
        checkOutput("reset_code", 32'(rep.code), 32'h0);
        checkOutput("reset_valid", 32'(rep.codeValid), 32'h0);
        checkOutput("reset_anyKey", 32'(anyKey), 32'h0);

        // Key 3 held from before edge 1: report after edge 19.
        resetL = 1'b1;
        keys   = 16'h0008;
        repeat (18) tick();
        checkOutput("k3_noValidEdge18", 32'(rep.codeValid), 32'h0);
        tick();
        checkOutput("k3_validEdge19", 32'(rep.codeValid), 32'h1);
        checkOutput("k3_code", 32'(rep.code), 32'h3);
        checkOutput("k3_anyKey", 32'(anyKey), 32'h1);
        ackOnce();
        checkOutput("k3_validDropsOnAck", 32'(rep.codeValid), 32'h0);
        checkOutput("k3_codeHeld", 32'(rep.code), 32'h3);
        keys = 16'h0000;
        watchQuiet(40, sawValid, sawAny);
        checkOutput("k3_noRepeat", 32'(sawValid), 32'h0);
        checkOutput("k3_anyKeyFalls", 32'(anyKey), 32'h0);

        // Highest index wins, then the lowest key alone.
        applyStimulus(16'h8001, n);
        checkOutput("k15_latency", 32'(n), 32'd19);
        checkOutput("k15_code", 32'(rep.code), 32'hF);
        ackOnce();
        keys = 16'h0000;
        repeat (40) tick();
        applyStimulus(16'h0001, n);
        checkOutput("k0_latency", 32'(n), 32'd19);
        checkOutput("k0_code", 32'(rep.code), 32'h0);
        ackOnce();
        keys = 16'h0000;
        repeat (40) tick();

        // 10-cycle glitch on key 5 is rejected but still seen on anyKey.
        keys = 16'h0020;
        watchQuiet(10, sawValid, sawAny);
        keys = 16'h0000;
        watchQuiet(30, sawValid2, sawAny2);
        checkOutput("glitch_noValid", 32'(sawValid | sawValid2), 32'h0);
        checkOutput("glitch_anyKeyPulse", 32'(sawAny), 32'h1);
        checkOutput("glitch_anyKeyFalls", 32'(anyKey), 32'h0);

        // enable low blocks a press; raising it starts debounce on the next edge.
        enable = 1'b0;
        keys   = 16'h0010;
        watchQuiet(30, sawValid, sawAny);
        checkOutput("en_blocked", 32'(sawValid), 32'h0);
        checkOutput("en_anyKeyIndependent", 32'(sawAny), 32'h1);
        enable = 1'b1;
        waitValid(60, n);
        checkOutput("en_latency", 32'(n), 32'd17);
        checkOutput("en_code", 32'(rep.code), 32'h4);
        enable = 1'b0;
        repeat (5) tick();
        checkOutput("en_lowKeepsReport", 32'(rep.codeValid), 32'h1);
        enable = 1'b1;
        ackOnce();
        keys = 16'h0000;
        repeat (40) tick();

        // Key 9 pressed while key 5 still held is never reported until re-pressed.
        applyStimulus(16'h0020, n);
        checkOutput("k5_latency", 32'(n), 32'd19);
        keys = 16'h0220;
        repeat (20) tick();
        checkOutput("k5_heldValid", 32'(rep.codeValid), 32'h1);
        checkOutput("k5_heldCode", 32'(rep.code), 32'h5);
        ackOnce();
        checkOutput("k5_acked", 32'(rep.codeValid), 32'h0);
        watchQuiet(30, sawValid, sawAny);
        keys = 16'h0200;
        watchQuiet(30, sawValid2, sawAny2);
        checkOutput("k9_noReportWhileHeld", 32'(sawValid | sawValid2), 32'h0);
        keys = 16'h0000;
        watchQuiet(30, sawValid, sawAny);
        checkOutput("k9_noReportOnRelease", 32'(sawValid), 32'h0);
        applyStimulus(16'h0200, n);
        checkOutput("k9_latency", 32'(n), 32'd19);
        checkOutput("k9_code", 32'(rep.code), 32'h9);
        ackOnce();
        keys = 16'h0000;
        repeat (40) tick();

        // Reset in the middle of debounce (cnt=8) discards it; a full debounce follows.
        keys = 16'h0004;
        repeat (11) tick();
        checkOutput("rst_midDebounceNoValid", 32'(rep.codeValid), 32'h0);
        resetL = 1'b0;
        #1;
        checkOutput("rst_codeCleared", 32'(rep.code), 32'h0);
        checkOutput("rst_validCleared", 32'(rep.codeValid), 32'h0);
        checkOutput("rst_anyKeyCleared", 32'(anyKey), 32'h0);
        tick();
        resetL = 1'b1;
        waitValid(60, n);
        checkOutput("rst_freshLatency", 32'(n), 32'd19);
        checkOutput("rst_code", 32'(rep.code), 32'h2);
        ackOnce();
        keys = 16'h0000;
        repeat (40) tick();

        // Key 7 held with acks: auto-repeat only when the feature is built in.
        applyStimulus(16'h0080, n);
        checkOutput("k7_latency", 32'(n), 32'd19);
        checkOutput("k7_code", 32'(rep.code), 32'h7);
        ackOnce();
`ifdef KEY_ENC_REPEAT_EN
        waitValid(300, n);
        checkOutput("k7_repeatLatency", 32'(n), 32'd256);
        checkOutput("k7_repeatCode", 32'(rep.code), 32'h7);
        ackOnce();
`else
        watchQuiet(300, sawValid, sawAny);
        checkOutput("k7_noRepeat", 32'(sawValid), 32'h0);
`endif
        keys = 16'h0000;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
